// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared FSM states, pairing codes and bit interleave helper for the ADC DDR capture
package adc_capture_pkg;
  typedef enum logic [1:0] {WAIT, TRAIN, LOCKED, FAIL} state_t;
  localparam logic PAIR_FALL_FIRST = 1'b0;
  localparam logic PAIR_RISE_FIRST = 1'b1;
  function automatic logic [63:0] interleave(input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[2*i+1] = hi[i];
      r[2*i]   = lo[i];
    end
    return r;
  endfunction
endpackage

// File: rtl/adc_ddr_lane.sv
// adc_ddr_lane: one LVDS lane, same-edge-pipelined DDR capture followed by dr1/df1/df2 alignment registers
module adc_ddr_lane (
  input  logic data_clk,
  input  logic rst_n,
  input  logic d,
  output logic dr1,
  output logic df1,
  output logic df2
);
  logic rcap, fcap, dr, df;
  always_ff @(negedge data_clk or negedge rst_n)
    if (!rst_n) fcap <= 1'b0;
    else fcap <= d;
  // rise and following fall of the same period leave the IDDR together on the next rising edge
  always_ff @(posedge data_clk or negedge rst_n)
    if (!rst_n) {rcap, dr, df, dr1, df1, df2} <= '0;
    else begin
      rcap <= d;
      dr   <= rcap;
      df   <= fcap;
      dr1  <= dr;
      df1  <= df;
      df2  <= df1;
    end
endmodule

// File: rtl/adc_ddr_capture_align.sv
// adc_ddr_capture_align: DDR ADC capture, rise/fall pairing training FSM and output pipeline.
// Optional pattern checker enabled by macro ADC_CAPTURE_PATCHK_EN.
module adc_ddr_capture_align
  import adc_capture_pkg::*;
#(
  parameter int               LANES         = 8,
  parameter int               PIPE_DEPTH    = 1,
  parameter int               RDY_CYCLES    = 4,
  parameter logic [2*LANES-1:0] TRAIN_PATTERN = 16'hA53C,
  parameter int               MATCH_COUNT   = 16,
  parameter int               TIMEOUT       = 4096
) (
  input  logic             data_clk,
  input  logic             reset_n,
  input  logic [LANES:0]   din,
  input  logic             train_req,
  input  logic             chk_en,
  output logic [2*LANES:0] data_out,
  output logic             data_valid,
  output logic             locked,
  output logic             train_fail,
  output logic             pair_sel,
  output logic [15:0]      err_cnt
);
  localparam int SW = 2 * LANES;
  localparam int RW = $clog2(RDY_CYCLES + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] rst_sync;
  logic rst_n;
  logic [LANES:0] dr1, df1, df2;
  logic [SW-1:0] samp0, samp1;
  logic [SW:0] asm_d;
  logic [SW:0] pipe [PIPE_DEPTH+1];
  logic [PIPE_DEPTH:0] vld;
  logic hit0, hit1, lock0, lock1;
  logic [RW-1:0] rdy_cnt;
  logic [MW-1:0] m0, m1;
  logic [TW-1:0] to_cnt;
  state_t state_q, state_d;
  logic unused_df1;
  always_ff @(posedge data_clk or negedge reset_n)
    if (!reset_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  for (genvar g = 0; g <= LANES; g++) begin : g_lane
    adc_ddr_lane u_lane (
      .data_clk (data_clk),
      .rst_n    (rst_n),
      .d        (din[g]),
      .dr1      (dr1[g]),
      .df1      (df1[g]),
      .df2      (df2[g])
    );
  end
  // both candidate pairings are built every clock so training can compare them side by side
  assign samp0 = SW'(interleave(32'(df2[LANES-1:0]), 32'(dr1[LANES-1:0])));
  assign samp1 = SW'(interleave(32'(dr1[LANES-1:0]), 32'(df1[LANES-1:0])));
  assign asm_d = pair_sel ? {dr1[LANES], samp1} : {df2[LANES], samp0};
  assign unused_df1 = df1[LANES];
  assign hit0  = samp0 == TRAIN_PATTERN;
  assign hit1  = samp1 == TRAIN_PATTERN;
  assign lock0 = hit0 && m0 == MW'(MATCH_COUNT - 1);
  assign lock1 = hit1 && m1 == MW'(MATCH_COUNT - 1);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT:    state_d = rdy_cnt == RW'(RDY_CYCLES - 1) ? TRAIN : WAIT;
      TRAIN:   state_d = (lock0 || lock1) ? LOCKED : to_cnt == TW'(TIMEOUT - 1) ? FAIL : TRAIN;
      default: state_d = state_q;
    endcase
    if (train_req) state_d = TRAIN;
    locked     = state_q == LOCKED;
    train_fail = state_q == FAIL;
    data_valid = locked && vld[PIPE_DEPTH];
  end
  always_ff @(posedge data_clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= WAIT;
      rdy_cnt  <= '0;
      m0       <= '0;
      m1       <= '0;
      to_cnt   <= '0;
      pair_sel <= PAIR_FALL_FIRST;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && rdy_cnt != RW'(RDY_CYCLES)) rdy_cnt <= rdy_cnt + 1'b1;
      if (state_q != TRAIN || train_req) begin
        m0     <= '0;
        m1     <= '0;
        to_cnt <= '0;
      end else begin
        m0     <= !hit0 ? MW'(0) : m0 == MW'(MATCH_COUNT) ? m0 : m0 + 1'b1;
        m1     <= !hit1 ? MW'(0) : m1 == MW'(MATCH_COUNT) ? m1 : m1 + 1'b1;
        to_cnt <= to_cnt == TW'(TIMEOUT) ? to_cnt : to_cnt + 1'b1;
      end
      if (state_d == FAIL) pair_sel <= PAIR_FALL_FIRST;
      else if (state_q == TRAIN && state_d == LOCKED) pair_sel <= lock0 ? PAIR_FALL_FIRST : PAIR_RISE_FIRST;
    end
  // valid rides along the pipeline so words assembled with a stale pairing are never flagged
  always_ff @(posedge data_clk or negedge rst_n)
    if (!rst_n) begin
      pipe <= '{default: '0};
      vld  <= '0;
    end else begin
      pipe[0] <= asm_d;
      vld[0]  <= state_q == LOCKED;
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        pipe[k] <= pipe[k-1];
        vld[k]  <= vld[k-1];
      end
    end
  assign data_out = pipe[PIPE_DEPTH];
`ifdef ADC_CAPTURE_PATCHK_EN
  logic [15:0] err_q;
  always_ff @(posedge data_clk or negedge rst_n)
    if (!rst_n) err_q <= '0;
    else if (train_req) err_q <= '0;
    else if (data_valid && chk_en && data_out[SW-1:0] != TRAIN_PATTERN && err_q != 16'hFFFF) err_q <= err_q + 1'b1;
  assign err_cnt = err_q;
`else
  logic unused_chk_en;
  assign unused_chk_en = chk_en;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_adc_ddr_capture_align.sv
// tb_adc_ddr_capture_align: directed bench with a DDR ADC lane model for adc_ddr_capture_align.
module tb_adc_ddr_capture_align;
  localparam logic [15:0] PAT = 16'hA53C;
  localparam int RDY = 4, MC = 16, TMO = 4096;
  // two-flop reset synchroniser delays the FSM start after reset_n release
  localparam int SYNC_LAT = 2;
  // a word loaded after edge P is compared at edge P+4 and reaches data_out at edge P+5
  localparam int CMP_LAT = 4, OUT_LAT = 5;
  logic data_clk = 1'b0;
  logic reset_n = 1'b1;
  logic train_req = 1'b0;
  logic chk_en = 1'b0;
  logic [8:0] din = '0;
  logic [16:0] data_out;
  logic data_valid, locked, train_fail, pair_sel;
  logic [15:0] err_cnt;
  logic [16:0] tx_word = {1'b0, PAT};
  logic [16:0] drv_w = '0;
  logic [16:0] exp_w;
  logic rise_first = 1'b0;
  logic rnd = 1'b0;
  int checks = 0, errors = 0;
  int n, or_seen;
  logic dv_seen;

  adc_ddr_capture_align dut (
    .data_clk   (data_clk),
    .reset_n    (reset_n),
    .din        (din),
    .train_req  (train_req),
    .chk_en     (chk_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .train_fail (train_fail),
    .pair_sel   (pair_sel),
    .err_cnt    (err_cnt)
  );

  always #10 data_clk = ~data_clk;

  function automatic logic [8:0] hi_of(input logic [16:0] w);
    logic [8:0] r;
    r[8] = w[16];
    for (int i = 0; i < 8; i++) r[i] = w[2*i+1];
    return r;
  endfunction

  function automatic logic [8:0] lo_of(input logic [16:0] w);
    logic [8:0] r;
    r[8] = w[16];
    for (int i = 0; i < 8; i++) r[i] = w[2*i];
    return r;
  endfunction

  function automatic logic [16:0] ramp(input int k);
    logic [16:0] r;
    r = {k % 100 == 0, k[15:0]};
    return r;
  endfunction

  // ADC model: each word occupies one clock; the odd bits go out first on fall-first links
  initial begin
    forever begin
      @(posedge data_clk);
      #5;
      if (!rise_first) drv_w = tx_word;
      din = rnd ? 9'($urandom) : rise_first ? lo_of(drv_w) : hi_of(drv_w);
      @(negedge data_clk);
      #5;
      if (rise_first) drv_w = tx_word;
      din = rnd ? 9'($urandom) : rise_first ? hi_of(drv_w) : lo_of(drv_w);
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    train_req = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_lock(input int bound, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!locked && cnt < bound);
  endtask

  task automatic test_reset();
    #5 reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    checks++;
    if ({data_valid, locked, train_fail, pair_sel} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {data_valid, locked, train_fail, pair_sel});
    end
    checks++;
    if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt: got %h expected 0", err_cnt); end
  endtask

  task automatic test_lock_fall();
    rnd = 1'b0;
    rise_first = 1'b0;
    tx_word = {1'b0, PAT};
    do_reset();
    wait_lock(100, n);
    checks++;
    if (n < RDY + MC - 2 || n > RDY + MC + 2) begin
      errors++; $display("FAIL fall_lock_time: got %0d clocks expected %0d..%0d", n, RDY + MC - 2, RDY + MC + 2);
    end
    checks++;
    if (pair_sel !== 1'b0) begin errors++; $display("FAIL fall_pair_sel: got %b expected 0", pair_sel); end
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL fall_inflight_valid: got %b expected 0", data_valid); end
    tick();
    tick();
    checks++;
    if (data_valid !== 1'b1) begin errors++; $display("FAIL fall_valid: got %b expected 1", data_valid); end
    checks++;
    if (data_out !== 17'h0A53C) begin errors++; $display("FAIL fall_data: got %h expected 0a53c", data_out); end
  endtask

  task automatic test_lock_rise();
    rnd = 1'b0;
    rise_first = 1'b1;
    tx_word = {1'b0, PAT};
    do_reset();
    wait_lock(100, n);
    checks++;
    if (n < RDY + MC - 2 || n > RDY + MC + 2) begin
      errors++; $display("FAIL rise_lock_time: got %0d clocks expected %0d..%0d", n, RDY + MC - 2, RDY + MC + 2);
    end
    checks++;
    if (pair_sel !== 1'b1) begin errors++; $display("FAIL rise_pair_sel: got %b expected 1", pair_sel); end
    tick();
    tick();
    checks++;
    if (data_out[15:0] !== PAT || data_valid !== 1'b1) begin
      errors++; $display("FAIL rise_data: got %h valid %b expected a53c valid 1", data_out[15:0], data_valid);
    end
    rise_first = 1'b0;
  endtask

  task automatic test_timeout();
    rnd = 1'b1;
    do_reset();
    n = 0;
    dv_seen = 1'b0;
    do begin
      tick();
      n++;
      if (data_valid) dv_seen = 1'b1;
    end while (!train_fail && n < 5000);
    checks++;
    if (n != RDY + TMO + SYNC_LAT) begin
      errors++; $display("FAIL timeout_time: got %0d clocks expected %0d", n, RDY + TMO + SYNC_LAT);
    end
    checks++;
    if (dv_seen !== 1'b0 || locked !== 1'b0 || pair_sel !== 1'b0) begin
      errors++; $display("FAIL timeout_flags: valid_seen %b locked %b pair_sel %b expected 0 0 0", dv_seen, locked, pair_sel);
    end
    repeat (10) tick();
    checks++;
    if (train_fail !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", train_fail); end
    train_req = 1'b1;
    tick();
    train_req = 1'b0;
    checks++;
    if (train_fail !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", train_fail); end
    rnd = 1'b0;
  endtask

  task automatic test_ramp();
    rnd = 1'b0;
    rise_first = 1'b0;
    tx_word = {1'b0, PAT};
    do_reset();
    wait_lock(100, n);
    tick();
    tick();
    or_seen = 0;
    for (int j = 0; j < 1000; j++) begin
      tick();
      exp_w = j >= OUT_LAT ? ramp(j - OUT_LAT) : {1'b0, PAT};
      if (data_out[16]) or_seen++;
      checks++;
      if (data_out !== exp_w || data_valid !== 1'b1) begin
        errors++; $display("FAIL ramp_%0d: got %h valid %b expected %h valid 1", j, data_out, data_valid, exp_w);
      end
      tx_word = ramp(j);
    end
    // ramp samples 0..994 reached the output; or is set on 0,100,...,900
    checks++;
    if (or_seen != 10) begin errors++; $display("FAIL ramp_or_count: got %0d expected 10", or_seen); end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || data_valid !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL ramp_async_reset: got %h valid %b locked %b expected 0 0 0", data_out, data_valid, locked);
    end
  endtask

  task automatic test_train_req();
    rnd = 1'b0;
    rise_first = 1'b0;
    tx_word = {1'b0, PAT};
    do_reset();
    wait_lock(100, n);
    repeat (3) tick();
    train_req = 1'b1;
    tick();
    train_req = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || locked !== 1'b0 || pair_sel !== 1'b0) begin
      errors++; $display("FAIL req_clear: valid %b locked %b pair_sel %b expected 0 0 0", data_valid, locked, pair_sel);
    end
    wait_lock(100, n);
    checks++;
    if (n != MC) begin errors++; $display("FAIL req_relock: got %0d clocks expected %0d", n, MC); end
    repeat (3) tick();
    train_req = 1'b1;
    tick();
    train_req = 1'b0;
    tick();
    tick();
    tx_word = 17'h00000;
    tick();
    tx_word = {1'b0, PAT};
    wait_lock(100, n);
    checks++;
    if (n + 1 != CMP_LAT + MC) begin
      errors++; $display("FAIL req_corrupt_relock: got %0d clocks expected %0d", n + 1, CMP_LAT + MC);
    end
  endtask

  task automatic test_checker();
    chk_en = 1'b1;
    repeat (3) tick();
`ifdef ADC_CAPTURE_PATCHK_EN
    for (int j = 0; j < 1000; j++) begin
      tick();
      tx_word = (j % 200 == 7) ? {1'b0, ~PAT} : {1'b0, PAT};
    end
    repeat (8) tick();
    checks++;
    if (err_cnt !== 16'd5) begin errors++; $display("FAIL chk_count: got %0d expected 5", err_cnt); end
    tick();
    force dut.err_q = 16'hFFFE;
    #1 release dut.err_q;
    for (int j = 0; j < 3; j++) begin
      tick();
      tx_word = {1'b0, ~PAT};
    end
    tick();
    tx_word = {1'b0, PAT};
    repeat (8) tick();
    checks++;
    if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL chk_saturate: got %h expected ffff", err_cnt); end
    train_req = 1'b1;
    tick();
    train_req = 1'b0;
    checks++;
    if (err_cnt !== 16'h0) begin errors++; $display("FAIL chk_clear: got %h expected 0", err_cnt); end
`else
    for (int j = 0; j < 3; j++) begin
      tick();
      tx_word = {1'b0, ~PAT};
    end
    tick();
    tx_word = {1'b0, PAT};
    repeat (8) tick();
    checks++;
    if (err_cnt !== 16'h0) begin errors++; $display("FAIL chk_disabled: got %h expected 0", err_cnt); end
`endif
    chk_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_fall();
    test_lock_rise();
    test_timeout();
    test_ramp();
    test_train_req();
    test_checker();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
